// File: rtl/delay_sched_pkg.sv
// delay_sched shared types and width helpers.
// Tag ids are stored at the widest supported size (16 requesters).
package delay_sched_pkg;

    localparam int ID_MAX_W = 4;

    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int cnt_w(input int m);
        return $clog2(m + 1);
    endfunction

    typedef struct packed {
        logic                valid;
        logic [ID_MAX_W-1:0] id;
    } tag_t;

endpackage

// File: rtl/delay_sched_rr_arbiter.sv
// Combinational round-robin pick: first eligible at or above i_ptr, wrapping.
// The pointer itself lives in the caller.
module rr_arbiter
    import delay_sched_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]          i_elig,
    input  logic [id_w(NUM_REQ)-1:0]    i_ptr,
    output logic [NUM_REQ-1:0]          o_grant,
    output logic [id_w(NUM_REQ)-1:0]    o_idx,
    output logic                        o_any
);
    localparam int ID_W = id_w(NUM_REQ);
    localparam logic [ID_W:0] N_L = (ID_W + 1)'(NUM_REQ);

    logic [NUM_REQ-1:0] w_rot;
    logic [ID_W-1:0]    w_off;
    logic [ID_W:0]      w_sum;

    always_comb begin
        // Rotate so bit k is requester (ptr + k) mod NUM_REQ
        w_rot = NUM_REQ'({i_elig, i_elig} >> i_ptr);
        o_any = 1'b0;
        w_off = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                o_any = 1'b1;
                w_off = ID_W'(k);
            end
        end
        w_sum = {1'b0, i_ptr} + {1'b0, w_off};
        o_idx = (w_sum >= N_L) ? ID_W'(w_sum - N_L) : ID_W'(w_sum);
        o_grant = o_any ? (NUM_REQ'(1) << o_idx) : '0;
    end

endmodule

// File: rtl/delay_sched.sv
// Round-robin scheduler for a shared fixed-latency pipe with credit limits
// and owner tags that re-emerge aligned with the pipe output.
module delay_sched
    import delay_sched_pkg::*;
#(
    parameter int NUM_REQ         = 4,
    parameter int WIDTH           = 14,
    parameter int LATENCY         = 6,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*WIDTH-1:0]   req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       pipe_valid_in,
    output logic [WIDTH-1:0]           pipe_data_in,
    input  logic [WIDTH-1:0]           pipe_data_out,
    output logic                       rsp_valid,
    output logic [id_w(NUM_REQ)-1:0]   rsp_id,
    output logic [WIDTH-1:0]           rsp_data
);
    localparam int ID_W = id_w(NUM_REQ);
    localparam int CW   = cnt_w(MAX_OUTSTANDING);
    localparam logic [CW-1:0] MAX_C = CW'(MAX_OUTSTANDING);

    logic [ID_W-1:0]    r_ptr;
    logic [CW-1:0]      r_cnt [NUM_REQ];
    tag_t               r_iss_tag;
    logic [WIDTH-1:0]   r_iss_data;
    tag_t               r_tag [LATENCY];

    logic [WIDTH-1:0]   w_req_d [NUM_REQ];
    logic [NUM_REQ-1:0] w_elig;
    logic [NUM_REQ-1:0] w_ret;
    logic [NUM_REQ-1:0] w_grant;
    logic [NUM_REQ-1:0] w_inc;
    logic [ID_W-1:0]    w_gidx;
    logic               w_any;
    logic               w_take;
    tag_t               w_out;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign w_req_d[g] = req_data[g*WIDTH +: WIDTH];
    end

    assign w_out = r_tag[LATENCY-1];

    // A slot returning this cycle frees its credit for an immediate regrant
    always_comb begin
        w_ret  = '0;
        w_elig = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_ret[i]  = w_out.valid && (w_out.id == ID_MAX_W'(i));
            w_elig[i] = req_valid[i] && ((r_cnt[i] < MAX_C) || w_ret[i]);
        end
    end

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .i_elig  (w_elig),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_gidx),
        .o_any   (w_any)
    );

    assign w_take    = w_any && !reset;
    assign w_inc     = w_take ? w_grant : '0;
    assign req_ready = reset ? '0 : w_grant;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr      <= '0;
            r_iss_tag  <= '0;
            r_iss_data <= '0;
        end else begin
            r_iss_tag.valid <= w_take;
            r_iss_tag.id    <= w_take ? ID_MAX_W'(w_gidx) : '0;
            if (w_take) begin
                r_iss_data <= w_req_d[w_gidx];
                r_ptr      <= (w_gidx == ID_W'(NUM_REQ - 1)) ? '0 : w_gidx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < LATENCY; i++) r_tag[i] <= '0;
        end else begin
            r_tag[0] <= r_iss_tag;
            for (int i = 1; i < LATENCY; i++) r_tag[i] <= r_tag[i-1];
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (reset) r_cnt[i] <= '0;
            else if (w_inc[i] && !w_ret[i]) r_cnt[i] <= r_cnt[i] + 1'b1;
            else if (!w_inc[i] && w_ret[i]) r_cnt[i] <= r_cnt[i] - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                assert (!(w_inc[i] && !w_ret[i] && r_cnt[i] == MAX_C));
                assert (!(w_ret[i] && !w_inc[i] && r_cnt[i] == '0));
            end
        end
    end

    assign pipe_valid_in = r_iss_tag.valid;
    assign pipe_data_in  = r_iss_data;
    assign rsp_valid     = w_out.valid;
    assign rsp_id        = w_out.id[ID_W-1:0];
    assign rsp_data      = pipe_data_out;

endmodule
